// File: rtl/a09_pkg.sv
// Shared definitions for the A09 sequencer: opcode map, writeback source
// encodings, FSM state type and the decoded instruction-class bundle.
package a09_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_LD   = 4'h7;
    localparam logic [3:0] OP_ST   = 4'h8;
    localparam logic [3:0] OP_JMP  = 4'h9;
    localparam logic [3:0] OP_BEQ  = 4'hA;
    localparam logic [3:0] OP_BNE  = 4'hB;
    localparam logic [3:0] OP_OUT  = 4'hC;
    localparam logic [3:0] OP_NOPD = 4'hD;
    localparam logic [3:0] OP_NOPE = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_IMM = 2'd1;
    localparam logic [1:0] WB_MEM = 2'd2;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEMWAIT,
        ST_WB,
        ST_HALT
    } state_t;

    typedef struct packed {
        logic alu;
        logic ldi;
        logic ld;
        logic st;
        logic jmp;
        logic br;
        logic out;
        logic hlt;
        logic nop;
    } instr_class_t;

endpackage

// File: rtl/a09_decode.sv
// Combinational opcode decoder: maps an opcode onto a one-hot instruction
// class plus the branch polarity (1 = branch when the ALU result is zero).
module a09_decode
    import a09_pkg::*;
#(
    parameter int OPC_WIDTH = 4
) (
    input  logic [OPC_WIDTH-1:0] opc,
    output instr_class_t         cls,
    output logic                 br_on_zero
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        cls        = '0;
        br_on_zero = 1'b0;
        case (opc)
            OPC_WIDTH'(OP_ADD), OPC_WIDTH'(OP_SUB), OPC_WIDTH'(OP_AND),
            OPC_WIDTH'(OP_OR),  OPC_WIDTH'(OP_XOR):  cls.alu = 1'b1;
            OPC_WIDTH'(OP_LDI):                      cls.ldi = 1'b1;
            OPC_WIDTH'(OP_LD):                       cls.ld  = 1'b1;
            OPC_WIDTH'(OP_ST):                       cls.st  = 1'b1;
            OPC_WIDTH'(OP_JMP):                      cls.jmp = 1'b1;
            OPC_WIDTH'(OP_BEQ): begin
                cls.br     = 1'b1;
                br_on_zero = 1'b1;
            end
            OPC_WIDTH'(OP_BNE):                      cls.br  = 1'b1;
            OPC_WIDTH'(OP_OUT):                      cls.out = 1'b1;
            OPC_WIDTH'(OP_HLT):                      cls.hlt = 1'b1;
            OPC_WIDTH'(OP_NOP), OPC_WIDTH'(OP_NOPD),
            OPC_WIDTH'(OP_NOPE):                     cls.nop = 1'b1;
            default:                                 cls.nop = 1'b1;
        endcase
    end

endmodule

// File: rtl/a09_sequencer.sv
// A09 control sequencer: fetch/decode/execute FSM driving the datapath
// strobes, with run/step control and an absorbing halt state.
module a09_sequencer
    import a09_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int OPC_WIDTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  run_i,
    input  logic                  step_i,
    input  logic [DATA_WIDTH-1:0] ir_i,
    input  logic                  zero_i,
    input  logic                  mem_ack_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic                  addr_sel_o,
    output logic                  ir_ld_o,
    output logic                  pc_ld_o,
    output logic                  pc_inc_o,
    output logic                  reg_we_o,
    output logic                  out_ld_o,
    output logic                  alu_ld_o,
    output logic [1:0]            wb_sel_o,
    output logic                  ready_o,
    output logic                  halt_o
);

    state_t       state;
    state_t       state_nxt;
    state_t       done_nxt;
    instr_class_t cls;
    logic         br_on_zero;
    logic         take_pc;
    logic         unused_bits;

    a09_decode #(.OPC_WIDTH(OPC_WIDTH)) u_decode (
        .opc        (ir_i[DATA_WIDTH-1 -: OPC_WIDTH]),
        .cls        (cls),
        .br_on_zero (br_on_zero)
    );

    assign unused_bits = ^{ir_i[DATA_WIDTH-OPC_WIDTH-1:0], cls.nop};
    assign take_pc     = cls.jmp | (cls.br & (br_on_zero ? zero_i : ~zero_i));
    assign done_nxt    = run_i ? ST_FETCH : ST_IDLE;

    always_ff @(posedge clk_i or posedge reset_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset_i) state <= ST_BOOT;
        else         state <= state_nxt;
    end

    // Strobes are decoded from the current state so they coincide with the
    // mem_ack_i cycle; BOOT (held by reset) decodes to all-zero outputs.
    always_comb begin
        state_nxt  = state;
        mem_req_o  = 1'b0;
        mem_we_o   = 1'b0;
        addr_sel_o = 1'b0;
        ir_ld_o    = 1'b0;
        pc_ld_o    = 1'b0;
        pc_inc_o   = 1'b0;
        reg_we_o   = 1'b0;
        out_ld_o   = 1'b0;
        alu_ld_o   = 1'b0;
        wb_sel_o   = WB_ALU;
        ready_o    = (state != ST_BOOT);
        halt_o     = (state == ST_HALT);
        case (state)
            ST_BOOT: state_nxt = ST_IDLE;
            ST_IDLE: if (run_i || step_i) state_nxt = ST_FETCH;
            ST_FETCH: begin
                mem_req_o = 1'b1;
                if (mem_ack_i) begin
                    ir_ld_o   = 1'b1;
                    pc_inc_o  = 1'b1;
                    state_nxt = ST_DECODE;
                end
            end
            ST_DECODE: state_nxt = ST_EXEC;
            ST_EXEC: begin
                state_nxt = done_nxt;
                pc_ld_o   = take_pc;
                out_ld_o  = cls.out;
                if (cls.alu) begin
                    alu_ld_o  = 1'b1;
                    state_nxt = ST_WB;
                end
                if (cls.ldi) begin
                    reg_we_o = 1'b1;
                    wb_sel_o = WB_IMM;
                end
                if (cls.ld || cls.st) state_nxt = ST_MEMWAIT;
                if (cls.hlt)          state_nxt = ST_HALT;
            end
            ST_MEMWAIT: begin
                mem_req_o  = 1'b1;
                addr_sel_o = 1'b1;
                mem_we_o   = cls.st;
                if (mem_ack_i) begin
                    if (cls.ld) begin
                        reg_we_o = 1'b1;
                        wb_sel_o = WB_MEM;
                    end
                    state_nxt = done_nxt;
                end
            end
            ST_WB: begin
                reg_we_o  = 1'b1;
                wb_sel_o  = WB_ALU;
                state_nxt = done_nxt;
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_BOOT;
        endcase
    end

endmodule
